// File: rtl/pcs_lane_pkg.sv
// Shared constants, lock-state encoding and bus slicing helpers for the PCS lane reorder path.
package pcs_lane_pkg;

   localparam int N_LANES     = 20;
   localparam int NB_ID       = $clog2(N_LANES);
   localparam int NB_DATA     = 66;
   localparam int NB_ID_BUS   = N_LANES * NB_ID;
   localparam int NB_DATA_BUS = N_LANES * NB_DATA;

   localparam logic [NB_ID-1:0] LAST_ID = NB_ID'(N_LANES - 1);

   typedef enum logic [1:0] {
      ST_WAIT_SEL = 2'd0,
      ST_CHECK    = 2'd1,
      ST_RUN      = 2'd2,
      ST_ERROR    = 2'd3
   } lane_state_t;

   function automatic logic [NB_ID-1:0] sel_field(input logic [NB_ID_BUS-1:0] bus, input int k);
      return bus[NB_ID*k +: NB_ID];
   endfunction

   function automatic logic [NB_DATA-1:0] lane_slice(input logic [NB_DATA_BUS-1:0] bus, input int k);
      return bus[NB_DATA*k +: NB_DATA];
   endfunction

endpackage

// File: rtl/lane_perm_check.sv
// Combinational check that a selector bus is a permutation of 0..N_LANES-1.
module lane_perm_check
   import pcs_lane_pkg::*;
(
   input  logic [NB_ID_BUS-1:0] sel_bus,
   output logic                 perm_ok
);

   logic [N_LANES-1:0] seen;
   logic [NB_ID-1:0]   field_k;

   always_comb begin
      seen    = '0;
      field_k = '0;
      perm_ok = 1'b1;
      for (int k = 0; k < N_LANES; k++) begin
         field_k = sel_field(sel_bus, k);
         if (field_k > LAST_ID) begin
            perm_ok = 1'b0;
         end else begin
            if (seen[field_k]) perm_ok = 1'b0;
            seen[field_k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lane_reorder_mux.sv
// Applies the latched lane selector as a permutation to the deskewed block bus.
// Build option LANE_REORDER_SEL_CHECK_EN adds the CHECK/ERROR permutation validation.
//
//   state    | meaning
//   WAIT_SEL | waiting for i_reorder_done, selector captured on it
//   CHECK    | one cycle to validate the captured selector
//   RUN      | locked, permuting valid blocks
//   ERROR    | selector was not a permutation, wait for i_reorder_done low
module lane_reorder_mux
   import pcs_lane_pkg::*;
(
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_enable,
   input  logic                   i_valid,
   input  logic                   i_reorder_done,
   input  logic [NB_ID_BUS-1:0]   i_reorder_mux_selector,
   input  logic [NB_DATA_BUS-1:0] i_data,
   output logic [NB_DATA_BUS-1:0] o_data,
   output logic                   o_valid,
   output logic                   o_locked,
   output logic                   o_sel_error
);

   lane_state_t            state;
   lane_state_t            state_next;
   logic [NB_ID_BUS-1:0]   sel_shadow;
   logic [NB_DATA_BUS-1:0] data_perm;
   logic [NB_DATA_BUS-1:0] data_q;
   logic                   valid_q;
   logic                   capture_sel;
   logic                   load_data;
   logic                   valid_next;
   logic [NB_ID-1:0]       sel_k;

   // Out-of-range fields leave their output lane at zero.
   always_comb begin
      data_perm = '0;
      sel_k     = '0;
      for (int k = 0; k < N_LANES; k++) begin
         sel_k = sel_field(sel_shadow, k);
         if (sel_k <= LAST_ID)
            data_perm[NB_DATA*k +: NB_DATA] = lane_slice(i_data, int'(sel_k));
      end
   end

`ifdef LANE_REORDER_SEL_CHECK_EN
   logic perm_ok;
   logic sel_error_q;

   lane_perm_check u_perm_check (
      .sel_bus (sel_shadow),
      .perm_ok (perm_ok)
   );
`endif

   always_comb begin
      state_next  = state;
      capture_sel = 1'b0;
      load_data   = 1'b0;
      valid_next  = 1'b0;
      case (state)
         ST_WAIT_SEL: begin
            if (i_reorder_done) begin
               capture_sel = 1'b1;
`ifdef LANE_REORDER_SEL_CHECK_EN
               state_next  = ST_CHECK;
`else
               state_next  = ST_RUN;
`endif
            end
         end
`ifdef LANE_REORDER_SEL_CHECK_EN
         ST_CHECK: begin
            state_next = perm_ok ? ST_RUN : ST_ERROR;
         end
         ST_ERROR: begin
            if (!i_reorder_done) state_next = ST_WAIT_SEL;
         end
`endif
         ST_RUN: begin
            if (i_valid) begin
               load_data  = 1'b1;
               valid_next = 1'b1;
            end
            if (!i_reorder_done) state_next = ST_WAIT_SEL;
         end
         default: state_next = ST_WAIT_SEL;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= ST_WAIT_SEL;
         sel_shadow <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else if (i_enable) begin
         state   <= state_next;
         valid_q <= valid_next;
         if (capture_sel) sel_shadow <= i_reorder_mux_selector;
         if (load_data)   data_q     <= data_perm;
      end else begin
         // Clearing here stops a held block from being replayed on resume.
         valid_q <= 1'b0;
      end
   end

`ifdef LANE_REORDER_SEL_CHECK_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sel_error_q <= 1'b0;
      end else if (i_enable) begin
         if (state == ST_CHECK && !perm_ok)
            sel_error_q <= 1'b1;
         else if (state == ST_ERROR && !i_reorder_done)
            sel_error_q <= 1'b0;
      end
   end

   assign o_sel_error = sel_error_q;
`else
   assign o_sel_error = 1'b0;
`endif

   assign o_data   = data_q;
   assign o_valid  = valid_q & i_enable;
   assign o_locked = (state == ST_RUN);

endmodule

// File: tb/tb_lane_reorder_mux.sv
// Randomized scoreboard bench for lane_reorder_mux with an array-based reference model.
module tb_lane_reorder_mux;

   localparam int NL = 20;
   localparam int NI = 5;
   localparam int NB = 66;

   localparam int M_WAIT  = 0;
   localparam int M_CHECK = 1;
   localparam int M_RUN   = 2;
   localparam int M_ERROR = 3;

   logic              i_clock = 1'b0;
   logic              i_reset;
   logic              i_enable;
   logic              i_valid;
   logic              i_reorder_done;
   logic [NL*NI-1:0]  i_reorder_mux_selector;
   logic [NL*NB-1:0]  i_data;
   logic [NL*NB-1:0]  o_data;
   logic              o_valid;
   logic              o_locked;
   logic              o_sel_error;

   always #5 i_clock = ~i_clock;

   lane_reorder_mux dut (
      .i_clock                (i_clock),
      .i_reset                (i_reset),
      .i_enable               (i_enable),
      .i_valid                (i_valid),
      .i_reorder_done         (i_reorder_done),
      .i_reorder_mux_selector (i_reorder_mux_selector),
      .i_data                 (i_data),
      .o_data                 (o_data),
      .o_valid                (o_valid),
      .o_locked               (o_locked),
      .o_sel_error            (o_sel_error)
   );

   typedef struct packed {
      logic             vld;
      logic             lock;
      logic             err;
      logic [NL*NB-1:0] held;
   } status_t;

   status_t          stat_q[$];
   logic [NL*NB-1:0] data_q[$];

   int              sel_tb[NL];
   logic [NB-1:0]   lane_tb[NL];
   int              m_map[NL];
   int              m_st;
   logic            m_vld;
   logic            m_err;
   logic [NL*NB-1:0] m_out;
   int              n_tests = 0;
   int              n_fail  = 0;
   int              cnt     = 0;

   function automatic bit map_is_perm();
      int seen[NL];
      for (int i = 0; i < NL; i++) seen[i] = 0;
      for (int i = 0; i < NL; i++) begin
         if (m_map[i] < 0 || m_map[i] >= NL) return 1'b0;
         seen[m_map[i]]++;
      end
      for (int i = 0; i < NL; i++) if (seen[i] != 1) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: advance the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      status_t s;
      if (i_reset) begin
         m_st = M_WAIT; m_vld = 1'b0; m_err = 1'b0; m_out = '0;
         for (int i = 0; i < NL; i++) m_map[i] = 0;
      end else if (!i_enable) begin
         m_vld = 1'b0;
      end else if (m_st == M_WAIT) begin
         m_vld = 1'b0;
         if (i_reorder_done) begin
            for (int i = 0; i < NL; i++) m_map[i] = sel_tb[i];
`ifdef LANE_REORDER_SEL_CHECK_EN
            m_st = M_CHECK;
`else
            m_st = M_RUN;
`endif
         end
      end else if (m_st == M_CHECK) begin
         m_vld = 1'b0;
         if (map_is_perm()) m_st = M_RUN;
         else begin m_st = M_ERROR; m_err = 1'b1; end
      end else if (m_st == M_ERROR) begin
         m_vld = 1'b0;
         if (!i_reorder_done) begin m_err = 1'b0; m_st = M_WAIT; end
      end else begin
         if (i_valid) begin
            m_out = '0;
            for (int i = 0; i < NL; i++)
               if (m_map[i] < NL) m_out[i*NB +: NB] = lane_tb[m_map[i]];
            m_vld = 1'b1;
            data_q.push_back(m_out);
         end else begin
            m_vld = 1'b0;
         end
         if (!i_reorder_done) m_st = M_WAIT;
      end
      s.vld  = m_vld;
      s.lock = (m_st == M_RUN);
      s.err  = m_err;
      s.held = m_out;
      stat_q.push_back(s);
   endtask

   task automatic tick(input logic v);
      i_valid = v;
      for (int i = 0; i < NL; i++) begin
         lane_tb[i] = {8'(i), 26'(cnt), 32'($urandom())};
         i_data[i*NB +: NB] = lane_tb[i];
         i_reorder_mux_selector[i*NI +: NI] = NI'(sel_tb[i]);
      end
      cnt++;
      model_step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic check_bit(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_data(input string nm, input logic [NL*NB-1:0] exp);
      n_tests++;
      if (o_data !== exp) begin
         n_fail++;
         for (int i = 0; i < NL; i++)
            if (o_data[i*NB +: NB] !== exp[i*NB +: NB]) begin
               $display("FAIL %s lane %0d: got %h expected %h at %0t",
                        nm, i, o_data[i*NB +: NB], exp[i*NB +: NB], $time);
               break;
            end
      end
   endtask

   // Monitor: one status entry per clock; data scoreboard popped only when o_valid.
   always @(negedge i_clock) begin
      status_t          s;
      logic [NL*NB-1:0] e;
      if (stat_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL status_queue: got empty expected entry at %0t", $time);
      end else begin
         s = stat_q.pop_front();
         check_bit("o_valid", o_valid, s.vld & i_enable);
         check_bit("o_locked", o_locked, s.lock);
         check_bit("o_sel_error", o_sel_error, s.err);
         if (o_valid) begin
            if (data_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL data_queue: got valid output expected none at %0t", $time);
            end else begin
               e = data_q.pop_front();
               check_data("o_data", e);
            end
         end else begin
            check_data("o_data_hold", s.held);
         end
      end
   end

   task automatic sel_identity();
      for (int i = 0; i < NL; i++) sel_tb[i] = i;
   endtask

   initial begin
      int j, t;
      i_reset = 1'b1; i_enable = 1'b1; i_reorder_done = 1'b0; i_valid = 1'b0;
      i_data = '0; i_reorder_mux_selector = '0;
      sel_identity();
      tick(0); tick(0);
      i_reset = 1'b0;

      // identity selector, continuous valid
      i_reorder_done = 1'b1;
      repeat (100) tick(1);

      // reverse selector; falling done with a valid block still outputs it
      i_reorder_done = 1'b0; tick(1); tick(0);
      for (int i = 0; i < NL; i++) sel_tb[i] = NL - 1 - i;
      i_reorder_done = 1'b1;
      repeat (60) tick(1'($urandom_range(0, 1)));

      // duplicate field: ERROR with check, duplicated lane without
      i_reorder_done = 1'b0; tick(0);
      sel_identity(); sel_tb[3] = 5; sel_tb[7] = 5;
      i_reorder_done = 1'b1;
      repeat (10) tick(1);
      i_reorder_done = 1'b0;
      repeat (3) tick(1);

      // out-of-range field: zero lane without check, ERROR with check
      sel_identity(); sel_tb[4] = 25;
      i_reorder_done = 1'b1;
      repeat (40) tick(1'($urandom_range(0, 1)));
      i_reorder_done = 1'b0; repeat (3) tick(0);

      // relock from reverse to rotate-by-1
      for (int i = 0; i < NL; i++) sel_tb[i] = NL - 1 - i;
      i_reorder_done = 1'b1;
      repeat (10) tick(1);
      i_reorder_done = 1'b0; tick(1);
      for (int i = 0; i < NL; i++) sel_tb[i] = (i + 1) % NL;
      repeat (3) tick(1);
      i_reorder_done = 1'b1;
      repeat (50) tick(1'($urandom_range(0, 1)));

      // enable low mid-stream, then reset pulse mid-RUN
      tick(0);
      i_enable = 1'b0;
      repeat (5) tick(1'($urandom_range(0, 1)));
      i_enable = 1'b1;
      repeat (20) tick(1'($urandom_range(0, 1)));
      tick(1);
      i_reset = 1'b1; tick(1);
      i_reset = 1'b0;
      repeat (20) tick(1'($urandom_range(0, 1)));

      // random permutations
      for (int r = 0; r < 3; r++) begin
         i_reorder_done = 1'b0; tick(0);
         sel_identity();
         for (int i = NL - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = sel_tb[i]; sel_tb[i] = sel_tb[j]; sel_tb[j] = t;
         end
         i_reorder_done = 1'b1;
         repeat (30) tick(1'($urandom_range(0, 1)));
      end

      i_reorder_done = 1'b0; tick(0);
      @(negedge i_clock);
      #1;
      n_tests++;
      if (data_q.size() != 0) begin
         n_fail++;
         $display("FAIL data_drain: got %0d blocks left expected 0", data_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lane_reorder_mux.md
Name: lane_reorder_mux

Overview:
Datapath stage directly downstream of the lane-reorder selector generator in the 100GbE PCS receive path. It takes the per-logical-lane selector bus once reordering is done, latches it and applies it as a permutation to the deskewed physical-lane block bus. The output is logical-lane-ordered 66b blocks for AM removal and descrambling. It owns the selector shadow register, a lock state machine and a one-stage output pipeline.

Parameters:
N_LANES, 20, number of PCS lanes
NB_ID, $clog2(N_LANES), bits per selector field
NB_ID_BUS, N_LANES*NB_ID, selector bus width
NB_DATA, 66, bits per lane block
NB_DATA_BUS, N_LANES*NB_DATA, data bus width

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  clock enable; low = hold all state and outputs, o_valid forced 0
i_valid  in  1  i_data valid this cycle
i_reorder_done  in  1  level; selector bus stable and complete
i_reorder_mux_selector  in  NB_ID_BUS  field k = physical lane carrying logical lane k
i_data  in  NB_DATA_BUS  deskewed blocks, physical-lane order
o_data  out  NB_DATA_BUS  blocks, logical-lane order
o_valid  out  1  o_data valid
o_locked  out  1  state == RUN
o_sel_error  out  1  latched selector not a permutation (only with check feature)

Behaviour:
- Field/lane packing: field k = bits [NB_ID*(k+1)-1 : NB_ID*k]; lane k = bits [NB_DATA*(k+1)-1 : NB_DATA*k]. The same convention applies to selector, i_data and o_data.
- Reset: state WAIT_SEL; sel_shadow=0; o_data=0; o_valid=0; o_locked=0; o_sel_error=0.
- All transitions and register updates are qualified by i_enable.
- WAIT_SEL:
  - On i_reorder_done=1, capture i_reorder_mux_selector into sel_shadow.
  - Go to CHECK if the feature is compiled in, else go to RUN.
  - o_valid=0.
- CHECK (one cycle): if sel_shadow is a valid permutation, go to RUN; else go to ERROR and set o_sel_error=1.
- ERROR: o_valid=0. On i_reorder_done=0, clear o_sel_error and return to WAIT_SEL.
- RUN:
  - When i_valid=1, o_data lane k <= i_data lane sel_shadow[k] and o_valid <= 1 (latency 1 cycle).
  - When i_valid=0, o_valid <= 0 and o_data holds.
- RUN, selector field ≥ N_LANES (only reachable without check): that output lane is all-zero.
- i_reorder_done falling in RUN (relock):
  - Next state WAIT_SEL; o_valid=0 from the next cycle.
  - o_data holds; sel_shadow holds until recaptured.
  - A valid block present in the same cycle is still output.
- i_reorder_done changing while in RUN without falling: ignored. The selector is only recaptured via WAIT_SEL.
- i_enable=0 mid-RUN: state frozen, o_valid=0. Resumes unchanged when i_enable returns to 1.
- Reset mid-operation: returns to reset values on the next edge; any in-flight block is dropped.

Optional Feature:
Macro LANE_REORDER_SEL_CHECK_EN.
- Defined: CHECK and ERROR states exist. Permutation check (each value 0..N_LANES-1 appears exactly once) is registered in CHECK. Lock latency is 2 cycles after i_reorder_done. o_sel_error is functional.
- Undefined: WAIT_SEL goes directly to RUN (lock latency 1 cycle). o_sel_error is tied 0. Out-of-range fields produce zero lanes.

Decomposition:
- Shared package pcs_lane_pkg: N_LANES, NB_DATA, NB_ID, the state encoding (WAIT_SEL=0, CHECK=1, RUN=2, ERROR=3), and the field/lane slice helper functions.
- One natural sub-module: lane_perm_check, a combinational permutation validator on NB_ID_BUS producing a 1-bit ok flag. It is instantiated only under the macro.

Test Plan:
1. Identity selector (field k=k), i_reorder_done=1, then 100 valid cycles of lane k = {k, counter} -> o_locked after 1 cycle (2 with check); o_data equals i_data, 1-cycle latency.
2. Reverse selector (field k=19-k) -> o_data lane 0 = i_data lane 19, lane 19 = i_data lane 0, every valid cycle; o_valid mirrors i_valid delayed by 1.
3. Check enabled, selector with field 3 = field 7 = 5 -> ERROR, o_sel_error=1, o_valid stays 0. Deassert i_reorder_done -> o_sel_error=0, back in WAIT_SEL.
4. Check disabled, field 4 = 25 -> o_data lane 4 = 0; all other lanes permuted correctly.
5. In RUN, drop i_reorder_done, then reassert with a new rotate-by-1 selector (field k = (k+1)%20) -> o_valid low during relock; after relock, lane k = i_data lane (k+1)%20.
6. i_enable low for 5 cycles mid-stream, plus i_reset pulsed mid-RUN -> outputs frozen and o_valid=0 while i_enable is low; reset returns all outputs to 0 and state to WAIT_SEL.
